// File: rtl/pic_host_pkg.sv
// Shared types and constants for the 8259 host-side bus master.
// Command constants are common PIC programming words.
package pic_host_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    GAP,
    INTA1,
    INTA_GAP,
    INTA2,
    VEC
  } state_e;

  localparam logic [7:0] ICW1_CMD    = 8'h13;
  localparam logic [7:0] OCW2_EOI    = 8'h20;
  localparam logic [7:0] OCW3_RD_IRR = 8'h0A;
  localparam logic [7:0] OCW3_RD_ISR = 8'h0B;

  function automatic logic cmd_phase(input state_e s);
    return (s == SETUP) || (s == PULSE) || (s == HOLD);
  endfunction

endpackage

// File: rtl/pic_int_sync.sv
// Flop chain bringing the asynchronous PIC INT into the clock domain.
// sync_next is the value sync_out will take on the next edge.
module pic_int_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic sync_next
);

  logic [STAGES-1:0] q;

  always_ff @(posedge clock) begin
    if (!reset_n) q <= '0;
    else          q <= {q[STAGES-2:0], async_in};
  end

  assign sync_out  = q[STAGES-1];
  assign sync_next = q[STAGES-2];

endmodule

// File: rtl/pic_host_bus_master.sv
// CPU-side initiator for the 8259 bus: timed RD/WR cycles and
// the two-pulse INTA sequence with vector capture.
module pic_host_bus_master
  import pic_host_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int GAP_CYCLES   = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       inta_enable,
  input  logic       interrupt_to_cpu,
  output logic       vector_valid,
  input  logic       vector_ready,
  output logic [7:0] vector,
  output logic       busy,
  output logic       chip_select_n,
  output logic       read_enable_n,
  output logic       write_enable_n,
  output logic       A0,
  output logic       interrupt_acknowledge_n,
  inout  wire  [7:0] data_bus
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d, a0_lat_q, a0_lat_d;
  logic [7:0]       dat_q, dat_d;
  logic             int_s, int_nx, hs, last, ph_d;

  logic       cs_n_q, rd_n_q, wr_n_q, a0_q, inta_n_q, drv_q;
  logic [7:0] dout_q, rsp_data_q, vec_q;
  logic       ready_q, rsp_valid_q, vv_q, busy_q;

  pic_int_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (interrupt_to_cpu),
    .sync_out (int_s),
    .sync_next(int_nx)
  );

  assign hs   = cmd_valid & ready_q;
  assign last = (cnt_q == '0);
  assign ph_d = cmd_phase(state_d);

  always_comb begin
    state_d  = state_q;
    cnt_d    = last ? cnt_q : cnt_q - CNT_W'(1);
    rd_d     = rd_q;
    a0_lat_d = a0_lat_q;
    dat_d    = dat_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d  = SETUP;
          cnt_d    = LD_SETUP;
          rd_d     = cmd_read;
          a0_lat_d = cmd_a0;
          dat_d    = cmd_data;
        end else if (inta_enable && int_s) begin
          state_d = INTA1;
          cnt_d   = LD_PULSE;
        end
      end
      SETUP:    if (last) begin state_d = PULSE;    cnt_d = LD_PULSE; end
      PULSE:    if (last) begin state_d = HOLD;     cnt_d = LD_HOLD;  end
      HOLD:     if (last) begin state_d = GAP;      cnt_d = LD_GAP;   end
      GAP:      if (last) state_d = IDLE;
      INTA1:    if (last) begin state_d = INTA_GAP; cnt_d = LD_GAP;   end
      INTA_GAP: if (last) begin state_d = INTA2;    cnt_d = LD_PULSE; end
      INTA2:    if (last) state_d = VEC;
      VEC: if (vector_ready) begin state_d = GAP; cnt_d = LD_GAP; end
      default:  state_d = IDLE;
    endcase
  end

  // Pins are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      a0_lat_q    <= 1'b0;
      dat_q       <= '0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      inta_n_q    <= 1'b1;
      a0_q        <= 1'b0;
      drv_q       <= 1'b0;
      dout_q      <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      vv_q        <= 1'b0;
      vec_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      a0_lat_q    <= a0_lat_d;
      dat_q       <= dat_d;
      cs_n_q      <= !ph_d;
      rd_n_q      <= !((state_d == PULSE) && rd_d);
      wr_n_q      <= !((state_d == PULSE) && !rd_d);
      inta_n_q    <= !((state_d == INTA1) || (state_d == INTA2));
      a0_q        <= ph_d && a0_lat_d;
      drv_q       <= ph_d && !rd_d;
      dout_q      <= dat_d;
      // Lookahead on the synchroniser keeps ready low when INTA wins.
      ready_q     <= (state_d == IDLE) && !(inta_enable && int_nx);
      rsp_valid_q <= (state_q == HOLD) && (state_d == GAP);
      vv_q        <= (state_d == VEC);
      busy_q      <= (state_d != IDLE);
      if (hs)
        rsp_data_q <= '0;
      else if ((state_q == PULSE) && last && rd_q)
        rsp_data_q <= data_bus;
      if ((state_q == INTA2) && last)
        vec_q <= data_bus;
    end
  end

  assign data_bus                = drv_q ? dout_q : 8'hzz;
  assign chip_select_n           = cs_n_q;
  assign read_enable_n           = rd_n_q;
  assign write_enable_n          = wr_n_q;
  assign interrupt_acknowledge_n = inta_n_q;
  assign A0                      = a0_q;
  assign cmd_ready               = ready_q;
  assign rsp_valid               = rsp_valid_q;
  assign rsp_data                = rsp_data_q;
  assign vector_valid            = vv_q;
  assign vector                  = vec_q;
  assign busy                    = busy_q;

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Directed bench for pic_host_bus_master with a simple PIC bus model.
// The model drives data_bus whenever RD or INTA is low.
module tb_pic_host_bus_master;
  import pic_host_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_read = 1'b0, cmd_a0 = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       inta_enable = 1'b0, interrupt_to_cpu = 1'b0;
  logic       vector_ready = 1'b0;
  logic       cmd_ready, rsp_valid, vector_valid, busy;
  logic [7:0] rsp_data, vector;
  logic       chip_select_n, read_enable_n, write_enable_n, A0;
  logic       interrupt_acknowledge_n;
  wire  [7:0] data_bus;

  logic       model_en;
  logic [7:0] model_val = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  assign model_en = !read_enable_n || !interrupt_acknowledge_n;
  assign data_bus = model_en ? model_val : 8'hzz;

  always #5 clock = ~clock;

  pic_host_bus_master dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_read               (cmd_read),
    .cmd_a0                 (cmd_a0),
    .cmd_data               (cmd_data),
    .rsp_valid              (rsp_valid),
    .rsp_data               (rsp_data),
    .inta_enable            (inta_enable),
    .interrupt_to_cpu       (interrupt_to_cpu),
    .vector_valid           (vector_valid),
    .vector_ready           (vector_ready),
    .vector                 (vector),
    .busy                   (busy),
    .chip_select_n          (chip_select_n),
    .read_enable_n          (read_enable_n),
    .write_enable_n         (write_enable_n),
    .A0                     (A0),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .data_bus               (data_bus)
  );

  function automatic logic rel(input logic [7:0] v);
    return (v === 8'h00) || (v === 8'hzz);
  endfunction

  // Issue one command and record 7 cycles after the handshake edge.
  // Bit k of each mask / element k is cycle k+1; released bus -> 00.
  task automatic issue(
    input  logic            rd,
    input  logic            a0,
    input  logic [7:0]      d,
    output logic            to,
    output logic [6:0]      cs_m,
    output logic [6:0]      wr_m,
    output logic [6:0]      rd_m,
    output logic [6:0]      a0_m,
    output logic [6:0]      rv_m,
    output logic [6:0][7:0] bt,
    output logic [7:0]      rdat
  );
    int n;
    to = 1'b0;
    rdat = 8'hEE;
    cs_m = '0; wr_m = '0; rd_m = '0; a0_m = '0; rv_m = '0; bt = '0;
    cmd_read = rd; cmd_a0 = a0; cmd_data = d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) to = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clock);
      cs_m[k] = !chip_select_n;
      wr_m[k] = !write_enable_n;
      rd_m[k] = !read_enable_n;
      a0_m[k] = A0;
      rv_m[k] = rsp_valid;
      bt[k]   = rel(data_bus) ? 8'h00 : data_bus;
      if (rsp_valid) rdat = rsp_data;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({chip_select_n, read_enable_n, write_enable_n,
         interrupt_acknowledge_n, A0} !== 5'b11110) begin
      n_bad++;
      $display("FAIL reset_pins: got %b want 11110",
        {chip_select_n, read_enable_n, write_enable_n,
         interrupt_acknowledge_n, A0});
    end
    n_cmp++;
    if ({cmd_ready, rsp_valid, vector_valid, busy} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000",
        {cmd_ready, rsp_valid, vector_valid, busy});
    end
    n_cmp++;
    if ({rsp_data, vector} !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0000", {rsp_data, vector});
    end
    n_cmp++;
    if (!rel(data_bus)) begin
      n_bad++;
      $display("FAIL reset_bus: got %h want released", data_bus);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    logic to;
    logic [6:0] cs_m, wr_m, rd_m, a0_m, rv_m;
    logic [6:0][7:0] bt;
    logic [7:0] rdat;
    issue(1'b0, 1'b0, ICW1_CMD, to, cs_m, wr_m, rd_m, a0_m, rv_m, bt, rdat);
    n_cmp++;
    if (to !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_accept: timeout got %b want 0", to);
    end
    n_cmp++;
    if (cs_m !== 7'b0001111) begin
      n_bad++;
      $display("FAIL wr_cs: got %b want 0001111", cs_m);
    end
    n_cmp++;
    if ({wr_m, rd_m} !== {7'b0000110, 7'b0}) begin
      n_bad++;
      $display("FAIL wr_strobe: got %b/%b want 0000110/0000000",
        wr_m, rd_m);
    end
    n_cmp++;
    if (a0_m !== 7'b0) begin
      n_bad++;
      $display("FAIL wr_a0: got %b want 0000000", a0_m);
    end
    n_cmp++;
    if (rv_m !== 7'b0010000) begin
      n_bad++;
      $display("FAIL wr_rsp: got %b want 0010000", rv_m);
    end
    n_cmp++;
    if (bt !== {8'h00, 8'h00, 8'h00, 8'h13, 8'h13, 8'h13, 8'h13}) begin
      n_bad++;
      $display("FAIL wr_bus: got %h want 00000013131313", bt);
    end
  endtask

  task automatic test_read();
    logic to;
    logic [6:0] cs_m, wr_m, rd_m, a0_m, rv_m;
    logic [6:0][7:0] bt;
    logic [7:0] rdat;
    model_val = 8'hA5;
    issue(1'b1, 1'b1, 8'h5A, to, cs_m, wr_m, rd_m, a0_m, rv_m, bt, rdat);
    n_cmp++;
    if ({rd_m, wr_m} !== {7'b0000110, 7'b0}) begin
      n_bad++;
      $display("FAIL rd_strobe: got %b/%b want 0000110/0000000",
        rd_m, wr_m);
    end
    n_cmp++;
    if ({cs_m, a0_m} !== {7'b0001111, 7'b0001111}) begin
      n_bad++;
      $display("FAIL rd_cs_a0: got %b/%b want 0001111/0001111",
        cs_m, a0_m);
    end
    n_cmp++;
    if (bt !== {8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00}) begin
      n_bad++;
      $display("FAIL rd_bus: got %h want 000000 00A5A500", bt);
    end
    n_cmp++;
    if ({rv_m, rdat} !== {7'b0010000, 8'hA5}) begin
      n_bad++;
      $display("FAIL rd_data: got %b/%h want 0010000/a5", rv_m, rdat);
    end
  endtask

  task automatic test_write_clears_rsp();
    logic to;
    logic [6:0] cs_m, wr_m, rd_m, a0_m, rv_m;
    logic [6:0][7:0] bt;
    logic [7:0] rdat;
    issue(1'b0, 1'b0, OCW3_RD_IRR, to, cs_m, wr_m, rd_m, a0_m, rv_m,
      bt, rdat);
    n_cmp++;
    if ({rv_m, rdat} !== {7'b0010000, 8'h00}) begin
      n_bad++;
      $display("FAIL wr_rsp_zero: got %b/%h want 0010000/00", rv_m, rdat);
    end
  endtask

  task automatic test_inta_stall();
    int n;
    logic [5:0] ia_m;
    logic cs_any, gap_drv;
    int stall_bad;
    ia_m = '0; cs_any = 1'b0; gap_drv = 1'b0; stall_bad = 0;
    inta_enable = 1'b1;
    model_val = 8'hFF;
    interrupt_to_cpu = 1'b1;
    n = 0;
    while (interrupt_acknowledge_n && n < 20) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL inta_latency: got %0d want 3", n);
    end
    interrupt_to_cpu = 1'b0;
    for (int j = 0; j < 6; j++) begin
      ia_m[j] = !interrupt_acknowledge_n;
      cs_any |= !chip_select_n;
      if (j == 2 || j == 3) gap_drv |= !rel(data_bus);
      if (j == 2) model_val = 8'h48;
      @(negedge clock);
    end
    n_cmp++;
    if (ia_m !== 6'b110011) begin
      n_bad++;
      $display("FAIL inta_pulses: got %b want 110011", ia_m);
    end
    n_cmp++;
    if ({cs_any, gap_drv} !== 2'b00) begin
      n_bad++;
      $display("FAIL inta_cs_bus: got %b want 00", {cs_any, gap_drv});
    end
    n_cmp++;
    if ({vector_valid, vector} !== {1'b1, 8'h48}) begin
      n_bad++;
      $display("FAIL inta_vector: got %b/%h want 1/48",
        vector_valid, vector);
    end
    for (int s = 0; s < 10; s++) begin
      if (vector_valid !== 1'b1 || vector !== 8'h48 ||
          cmd_ready !== 1'b0 || busy !== 1'b1)
        stall_bad++;
      @(negedge clock);
    end
    n_cmp++;
    if (stall_bad !== 0) begin
      n_bad++;
      $display("FAIL vec_stall: got %0d bad cycles want 0", stall_bad);
    end
    vector_ready = 1'b1;
    @(negedge clock);
    vector_ready = 1'b0;
    n_cmp++;
    if ({vector_valid, cmd_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL vec_release: got %b want 00",
        {vector_valid, cmd_ready});
    end
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL vec_idle: got %b want 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_collision();
    int first_inta, first_cs, vcons, acc, overlap;
    logic pend;
    logic [7:0] vseen;
    first_inta = -1; first_cs = -1; vcons = -1; acc = -1; overlap = 0;
    pend = 1'b0; vseen = 8'h00;
    cmd_read = 1'b0; cmd_a0 = 1'b0; cmd_data = OCW3_RD_ISR;
    model_val = 8'h30;
    interrupt_to_cpu = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clock);
      if (pend) begin cmd_valid = 1'b0; pend = 1'b0; end
      vector_ready = 1'b0;
      if (i == 2) cmd_valid = 1'b1;
      if (!interrupt_acknowledge_n) begin
        interrupt_to_cpu = 1'b0;
        if (first_inta < 0) first_inta = i;
      end
      if (!chip_select_n) begin
        if (!interrupt_acknowledge_n) overlap++;
        if (first_cs < 0) first_cs = i;
      end
      if (vector_valid && vcons < 0) begin
        vcons = i;
        vseen = vector;
        vector_ready = 1'b1;
      end
      if (cmd_valid && cmd_ready && acc < 0) begin
        acc = i;
        pend = 1'b1;
      end
    end
    n_cmp++;
    if (first_inta !== 3 || vcons !== 9) begin
      n_bad++;
      $display("FAIL col_inta: got inta@%0d vec@%0d want 3/9",
        first_inta, vcons);
    end
    n_cmp++;
    if (acc !== 12 || first_cs !== 13) begin
      n_bad++;
      $display("FAIL col_accept: got acc@%0d cs@%0d want 12/13",
        acc, first_cs);
    end
    n_cmp++;
    if ({overlap, vseen} !== {32'd0, 8'h30}) begin
      n_bad++;
      $display("FAIL col_overlap: got %0d/%h want 0/30", overlap, vseen);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic rv_seen;
    logic to;
    logic [6:0] cs_m, wr_m, rd_m, a0_m, rv_m;
    logic [6:0][7:0] bt;
    logic [7:0] rdat;
    rv_seen = 1'b0;
    cmd_read = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'h55; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (write_enable_n !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_pulse: got %b want 0", write_enable_n);
    end
    reset_n = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({chip_select_n, read_enable_n, write_enable_n,
         interrupt_acknowledge_n, A0, rsp_valid} !== 6'b111100) begin
      n_bad++;
      $display("FAIL rmid_pins: got %b want 111100",
        {chip_select_n, read_enable_n, write_enable_n,
         interrupt_acknowledge_n, A0, rsp_valid});
    end
    n_cmp++;
    if (!rel(data_bus)) begin
      n_bad++;
      $display("FAIL rmid_bus: got %h want released", data_bus);
    end
    repeat (2) begin
      @(negedge clock);
      rv_seen |= rsp_valid;
    end
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      rv_seen |= rsp_valid;
    end
    n_cmp++;
    if (rv_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_no_rsp: got %b want 0", rv_seen);
    end
    issue(1'b0, 1'b1, OCW2_EOI, to, cs_m, wr_m, rd_m, a0_m, rv_m,
      bt, rdat);
    n_cmp++;
    if ({rv_m, a0_m, wr_m} !==
        {7'b0010000, 7'b0001111, 7'b0000110}) begin
      n_bad++;
      $display("FAIL rmid_after: got %b/%b/%b want 0010000/0001111/0000110",
        rv_m, a0_m, wr_m);
    end
    n_cmp++;
    if (bt !== {8'h00, 8'h00, 8'h00, 8'h20, 8'h20, 8'h20, 8'h20}) begin
      n_bad++;
      $display("FAIL rmid_bus_after: got %h want 00000020202020", bt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    test_reset();
    test_write();
    test_read();
    test_write_clears_rsp();
    test_inta_stall();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
